univ_shift_reg_burst: RTL

//  Parametrised successor to the 4-bit 74HC194 universal shift register. Same 4-way mode

---
 rtl/univ_shift_reg_burst.sv | 136 +++++++++++++
 1 files changed

// File: rtl/univ_shift_reg_burst.sv
// Purpose: parametrised universal shift register (hold/shr/shl/load) with rotate and a burst shift engine.
// Latency: Q updates on the clock edge that applies the mode; a burst shifts on edges k+1..k+CNT after START at edge k.
// Backpressure: none; START is ignored while BUSY, and S/D/START are not looked at during a burst.
//
// Ports:
//   CP            rising-edge clock
//   MR            asynchronous active-low master reset
//   S[1:0]        mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   DSR / DSL     serial inputs for shift right (enters Q[0]) / shift left (enters Q[WIDTH-1])
//   D[0:WIDTH-1]  parallel load data
//   ROT           rotate: the end-around bit replaces the serial input
//   START / CNT   burst request and burst length (direction taken from S)
//   Q[0:WIDTH-1]  register contents, Q[0] leftmost
//   SOR / SOL     Q[WIDTH-1] / Q[0]
//   BUSY / DONE   burst in progress / one-cycle pulse after the final burst shift
//   PAR           registered even parity of Q when UNIV_SR_PARITY_EN is defined, else tied 0
//
// Optional feature macro: UNIV_SR_PARITY_EN
module univ_shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [0:WIDTH-1] D,
  input  logic             ROT,
  input  logic             START,
  input  logic [CNT_W-1:0] CNT,
  output logic [0:WIDTH-1] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             BUSY,
  output logic             DONE,
  output logic             PAR
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_nxt;
  logic [0:WIDTH-1] q_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             dir_left_q, dir_left_nxt;
  logic             busy_nxt, done_nxt;
  logic [0:WIDTH-1] shr_val, shl_val;
  logic             start_ok;

  // Serial inputs and ROT are sampled live, so both candidate shift results are always ready.
  assign shr_val = {(ROT ? Q[WIDTH-1] : DSR), Q[0:WIDTH-2]};
  assign shl_val = {Q[1:WIDTH-1], (ROT ? Q[0] : DSL)};

  // Only a real shift direction with a non-zero length starts a burst; anything else is a plain edge.
  assign start_ok = START && (CNT != '0) && ((S == 2'b01) || (S == 2'b10));

  assign SOR = Q[WIDTH-1];
  assign SOL = Q[0];

  always_comb begin
    state_nxt    = state_q;
    q_nxt        = Q;
    cnt_nxt      = cnt_q;
    dir_left_nxt = dir_left_q;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          // Accepting edge only latches the burst; the first shift happens on the next edge.
          dir_left_nxt = (S == 2'b10);
          cnt_nxt      = CNT;
          busy_nxt     = 1'b1;
          state_nxt    = BURST;
        end else begin
          case (S)
            2'b01:   q_nxt = shr_val;
            2'b10:   q_nxt = shl_val;
            2'b11:   q_nxt = D;
            default: q_nxt = Q;
          endcase
        end
      end
      BURST: begin
        q_nxt   = dir_left_q ? shl_val : shr_val;
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state_q    <= IDLE;
      Q          <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      Q          <= q_nxt;
      cnt_q      <= cnt_nxt;
      dir_left_q <= dir_left_nxt;
      BUSY       <= busy_nxt;
      DONE       <= done_nxt;
    end
  end

`ifdef UNIV_SR_PARITY_EN
  logic par_q;

  // Parity of the value Q takes on this edge, so PAR tracks Q without a cycle of lag.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^q_nxt;
    end
  end

  assign PAR = par_q;
`else
  assign PAR = 1'b0;
`endif

endmodule
